// File: rtl/ad_pkg.sv
// Shared types and default widths for the ADC acquisition controller.
package ad_pkg;

    localparam int AD_DATA_W = 8;
    localparam int AD_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ad_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module ad_capture_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read-before-write: a same-cycle read of the written address sees old data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_rdata <= '0;
        else
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ad_capture_ctrl.sv
// Arm / trigger / capture sequencer for the 8-bit ADC stream, storing
// decimated samples into an internal buffer for host readback.
module ad_capture_ctrl
    import ad_pkg::*;
#(
    parameter int DATA_W = AD_DATA_W,
    parameter int ADDR_W = AD_ADDR_W
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              trig_en,
    input  logic              trig_rising,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [ADDR_W:0]   capture_len,
    input  logic [7:0]        decim,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_vld,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W:0]   sample_cnt,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    logic              r_busy;
    logic              r_triggered;
    logic              r_done;
    logic [ADDR_W:0]   r_cnt;
    logic [7:0]        r_dcnt;
    logic [DATA_W-1:0] r_prev;
    logic              r_trig_en;
    logic              r_trig_rising;
    logic [DATA_W-1:0] r_level;
    logic [ADDR_W:0]   r_len;
    logic [7:0]        r_decim;

    logic [ADDR_W:0]   w_len_eff;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              w_fire;
    logic              w_last;
    logic              w_we;

    assign w_len_eff = (capture_len == '0 || capture_len > DEPTH) ? DEPTH : capture_len;
    assign w_cnt_nxt = r_cnt + (ADDR_W+1)'(1);
    assign w_last    = (w_cnt_nxt == r_len);
    assign w_fire    = r_trig_rising ? (r_prev <  r_level && ad_data >= r_level)
                                     : (r_prev >= r_level && ad_data <  r_level);

    // Every buffer write is a kept sample; abort suppresses a coincident write.
    always_comb begin
        w_we = 1'b0;
        if (ad_vld && !abort) begin
            case (r_state)
                ST_WAIT_FIRST: w_we = !r_trig_en;
                ST_WAIT_TRIG:  w_we = w_fire;
                ST_CAPTURE:    w_we = (r_dcnt == r_decim);
                default:       w_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_triggered   <= 1'b0;
            r_done        <= 1'b0;
            r_cnt         <= '0;
            r_dcnt        <= '0;
            r_prev        <= '0;
            r_trig_en     <= 1'b0;
            r_trig_rising <= 1'b0;
            r_level       <= '0;
            r_len         <= '0;
            r_decim       <= '0;
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_triggered <= 1'b0;
        end else if (w_we) begin
            r_cnt  <= w_cnt_nxt;
            r_dcnt <= '0;
            if (w_last) begin
                r_state     <= ST_DONE;
                r_busy      <= 1'b0;
                r_triggered <= 1'b0;
                r_done      <= 1'b1;
            end else begin
                r_state     <= ST_CAPTURE;
                r_triggered <= 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_WAIT_FIRST;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_cnt         <= '0;
                        r_dcnt        <= '0;
                        r_trig_en     <= trig_en;
                        r_trig_rising <= trig_rising;
                        r_level       <= trig_level;
                        r_len         <= w_len_eff;
                        r_decim       <= decim;
                    end
                end
                ST_WAIT_FIRST: begin
                    if (ad_vld) begin
                        r_prev  <= ad_data;
                        r_state <= ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (ad_vld)
                        r_prev <= ad_data;
                end
                ST_CAPTURE: begin
                    if (ad_vld)
                        r_dcnt <= r_dcnt + 8'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ad_capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (sys_clk),
        .i_rst_n (rst_n),
        .i_we    (w_we),
        .i_waddr (r_cnt[ADDR_W-1:0]),
        .i_wdata (ad_data),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign busy       = r_busy;
    assign triggered  = r_triggered;
    assign done       = r_done;
    assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// Directed + randomized bench for ad_capture_ctrl against a list-based model.
module tb_ad_capture_ctrl;

    localparam int DEPTH = 256;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       trig_en = 1'b0;
    logic       trig_rising = 1'b0;
    logic [7:0] trig_level = '0;
    logic [8:0] capture_len = '0;
    logic [7:0] decim = '0;
    logic [7:0] ad_data = '0;
    logic       ad_vld = 1'b0;
    logic       busy;
    logic       triggered;
    logic       done;
    logic [8:0] sample_cnt;
    logic [7:0] rd_addr = '0;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    ad_capture_ctrl dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .trig_en     (trig_en),
        .trig_rising (trig_rising),
        .trig_level  (trig_level),
        .capture_len (capture_len),
        .decim       (decim),
        .ad_data     (ad_data),
        .ad_vld      (ad_vld),
        .busy        (busy),
        .triggered   (triggered),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    // Which sample indices end up in the buffer: find the trigger position in
    // the stream, then take every (dec+1)-th sample from there, up to the length.
    function automatic void model(input bit ten, input bit rise, input int lvl,
                                  input int len, input int dec, input int s[$],
                                  output int kept[$]);
        int t;
        int eff;
        bit f;
        t = -1;
        eff = (len == 0 || len > DEPTH) ? DEPTH : len;
        kept.delete();
        if (s.size() == 0) return;
        if (!ten) t = 0;
        else begin
            for (int i = 1; i < s.size(); i++) begin
                f = rise ? (s[i-1] < lvl && s[i] >= lvl) : (s[i-1] >= lvl && s[i] < lvl);
                if (f && t < 0) t = i;
            end
        end
        if (t < 0) return;
        for (int idx = t; idx < s.size() && kept.size() < eff; idx += dec + 1)
            kept.push_back(idx);
    endfunction

    task automatic run(input string nm, input bit ten, input bit rise, input int lvl,
                       input int len, input int dec, input int s[$],
                       input int gap_max, input int start_at);
        int kept[$];
        int eff;
        int ec;
        model(ten, rise, lvl, len, dec, s, kept);
        eff = (len == 0 || len > DEPTH) ? DEPTH : len;
        trig_en = ten; trig_rising = rise; trig_level = 8'(lvl);
        capture_len = 9'(len); decim = 8'(dec);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk($sformatf("%s busy_after_start", nm), 32'(busy), 1);
        chk($sformatf("%s done_after_start", nm), 32'(done), 0);
        chk($sformatf("%s cnt_after_start", nm), 32'(sample_cnt), 0);
        // Config must have been latched at start; scramble the live inputs.
        trig_en = 1'($urandom); trig_rising = 1'($urandom);
        trig_level = 8'($urandom); capture_len = 9'($urandom); decim = 8'($urandom);
        ec = 0;
        for (int p = 0; p < s.size(); p++) begin
            repeat ($urandom_range(gap_max, 0)) cyc();
            ad_data = 8'(s[p]);
            ad_vld = 1'b1;
            if (p == start_at) start = 1'b1;
            cyc();
            ad_vld = 1'b0;
            start = 1'b0;
            while (ec < kept.size() && kept[ec] <= p) ec++;
            chk($sformatf("%s cnt p%0d", nm, p), 32'(sample_cnt), 32'(ec));
            chk($sformatf("%s done p%0d", nm, p), 32'(done), 32'(ec == eff));
            chk($sformatf("%s busy p%0d", nm, p), 32'(busy), 32'(ec != eff));
            chk($sformatf("%s trig p%0d", nm, p), 32'(triggered), 32'(ec > 0 && ec < eff));
        end
        for (int k = 0; k < kept.size(); k++) begin
            rd_addr = 8'(k);
            cyc();
            chk($sformatf("%s ram[%0d]", nm, k), 32'(rd_data), 32'(s[kept[k]]));
        end
        if (busy) begin
            abort = 1'b1;
            cyc();
            abort = 1'b0;
        end
    endtask

    task automatic feed(input int d);
        ad_data = 8'(d);
        ad_vld = 1'b1;
        cyc();
        ad_vld = 1'b0;
    endtask

    initial begin
        int s[$];
        repeat (3) cyc();
        chk("reset busy", 32'(busy), 0);
        chk("reset triggered", 32'(triggered), 0);
        chk("reset done", 32'(done), 0);
        chk("reset sample_cnt", 32'(sample_cnt), 0);
        chk("reset rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        cyc();

        s = '{10, 20, 30, 40, 50};
        run("immediate", 0, 0, 0, 4, 0, s, 1, -1);
        s = '{'h70, 'h7F, 'h80, 'h90};
        run("rising", 1, 1, 'h80, 2, 0, s, 1, -1);
        s = '{'h90, 'h85, 'h7F};
        run("falling", 1, 0, 'h80, 1, 0, s, 0, -1);
        s.delete();
        for (int i = 0; i < 16; i++) s.push_back('h81 + i);
        run("falling_notrig", 1, 0, 'h80, 4, 0, s, 1, -1);
        s = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        run("decim2", 0, 0, 0, 3, 2, s, 0, -1);

        // Abort after five writes, then a start coinciding with abort.
        trig_en = 1'b0; capture_len = 9'd10; decim = 8'd0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 5; i++) feed(i + 1);
        chk("abort pre triggered", 32'(triggered), 1);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        chk("abort triggered", 32'(triggered), 0);
        chk("abort sample_cnt", 32'(sample_cnt), 5);
        feed(99);
        chk("abort idle_cnt", 32'(sample_cnt), 5);
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        chk("start+abort busy", 32'(busy), 0);
        feed(98);
        chk("start+abort cnt", 32'(sample_cnt), 5);

        // Full-depth capture with a start pulse during CAPTURE.
        s.delete();
        for (int i = 0; i < DEPTH + 4; i++) s.push_back(int'($urandom_range(255, 0)));
        run("len0", 0, 0, 0, 0, 0, s, 0, 100);

        for (int r = 0; r < 8; r++) begin
            int n;
            s.delete();
            n = int'($urandom_range(80, 40));
            for (int i = 0; i < n; i++) s.push_back(int'($urandom_range(255, 0)));
            run($sformatf("rand%0d", r), 1'($urandom), 1'($urandom),
                int'($urandom_range(255, 0)), int'($urandom_range(24, 1)),
                int'($urandom_range(3, 0)), s, 2, -1);
        end

        // Reset mid-capture clears outputs without a clock edge.
        trig_en = 1'b0; capture_len = 9'd20; decim = 8'd0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 5; i++) feed('h55);
        rd_addr = 8'd2;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", 32'(busy), 0);
        chk("midreset triggered", 32'(triggered), 0);
        chk("midreset done", 32'(done), 0);
        chk("midreset sample_cnt", 32'(sample_cnt), 0);
        chk("midreset rd_data", 32'(rd_data), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
